ghost_wall_sense: RTL and testbench
===================================

Name: ghost_wall_sense

Overview:
- Upstream neighbour of the ghost movement stages. Once per frame it probes the maze tile ROM one pixel beyond the ghost's bounding box in all four directions.
- It registers UpWall/DownWall/LeftWall/RightWall for the ghost FSM to consume on its next frame_clk edge.
- Runs on the 50 MHz system clock. Detects frame_clk rising edges internally and sequences four reads to a synchronous 1-cycle-latency ROM.

Parameters:
- MAP_COLS, 40, tiles per maze row (640/16).
- MAP_ROWS, 30, tile rows (480/16).
- TILE_SHIFT, 4, log2 of tile size in pixels.
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= MAP_COLS*MAP_ROWS.
- SYNC_STAGES, 2, frame_clk synchronizer depth.

Ports:
- Clk  in  1  system clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame strobe from the VGA controller; asynchronous to Clk.
- GhostX  in  10  ghost centre X, pixels.
- GhostY  in  10  ghost centre Y, pixels.
- GhostS  in  10  ghost half-size, pixels.
- rom_addr  out  ADDR_W  tile ROM address = row*MAP_COLS + col.
- rom_rd  out  1  ROM read enable.
- rom_data  in  2  tile code; valid the cycle after rom_rd.
- UpWall  out  1  wall directly above.
- DownWall  out  1  wall directly below.
- LeftWall  out  1  wall directly left.
- RightWall  out  1  wall directly right.
- walls_valid  out  1  one-cycle pulse when the four wall outputs update.

Behaviour:
- Reset (Reset=0, async): all outputs 0; FSM to IDLE; pending flag cleared; synchronizer flops cleared.
- Edge detect: frame_clk passes through SYNC_STAGES flops plus one history flop. A rise gives a 1-cycle frame_evt.
- FSM states: IDLE, RD_UP, RD_DN, RD_LT, RD_RT, LAST.
- IDLE: on frame_evt or pending=1, capture GhostX/Y/S into local registers, clear pending, go to RD_UP.
- Probe points, computed in 11-bit signed arithmetic:
  - up: (X, Y-S-1)
  - down: (X, Y+S+1)
  - left: (X-S-1, Y)
  - right: (X+S+1, Y)
  - col = px>>TILE_SHIFT; row = py>>TILE_SHIFT.
- Out-of-range probe (coordinate <0, col >= MAP_COLS, or row >= MAP_ROWS): rom_rd=0 in that slot; that direction is forced to wall=1.
- RD_UP, RD_DN, RD_LT, RD_RT: each drives rom_addr and rom_rd for its own probe. Each also samples rom_data returned for the previous slot. Order is fixed up, down, left, right.
- LAST: samples the right-probe data. At the end of LAST, all four outputs load together and walls_valid=1 for exactly one cycle. Return to IDLE.
- Latency: outputs change 6 Clk cycles after frame_evt, far inside one frame. Outputs hold between updates, so the ghost FSM always sees a stable, coherent set.
- Wall decode: tile code TILE_WALL or TILE_GATE is a wall; TILE_EMPTY and TILE_DOT are not.
- Busy collision: a frame_evt while not in IDLE sets pending. Multiple events collapse into one. Pending is serviced immediately after LAST.
- rom_addr holds its last value when rom_rd=0.
- Reset asserted mid-sequence aborts the sequence. Outputs return to 0 and no walls_valid pulse occurs.

Optional Feature:
- Macro GHOST_GATE_PASS_EN.
- Defined: TILE_GATE decodes as non-wall, so ghosts can exit the pen.
- Undefined: gate is a wall, per the Behaviour section.

Decomposition:
- Package maze_pkg holds:
  - tile_t enum (TILE_EMPTY=0, TILE_WALL=1, TILE_DOT=2, TILE_GATE=3)
  - MAP_COLS, MAP_ROWS, TILE_SHIFT constants
  - dir_t enum (DIR_UP, DIR_DN, DIR_LT, DIR_RT)
  - ws_state_t FSM enum
- Sub-module maze_probe_addr: combinational pixel-to-address converter with an out-of-range flag. Instantiated once; its probe input is muxed by FSM state.

Test Plan:
- Ghost (231,240), S=9, ROM all empty, one frame_clk rise -> reads at addresses 574, 614, 613, 615 in that order on consecutive cycles; walls all 0; walls_valid one pulse 6 cycles after frame_evt.
- Same position, ROM[574]=WALL, ROM[615]=GATE, macro undefined -> UpWall=1, RightWall=1, others 0. With GHOST_GATE_PASS_EN defined -> RightWall=0.
- Ghost (635,5), S=9 -> up and right probes out of range, rom_rd low in those slots; UpWall=1, RightWall=1 regardless of ROM.
- Three frame_clk rises while in RD_DN -> exactly two complete sequences in total, back-to-back; two walls_valid pulses.
- Reset pulsed low during RD_LT after a prior result of all-1 walls -> outputs 0 immediately; no walls_valid; next frame_clk rise runs a clean sequence.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze definitions: tile codes, map geometry, probe directions and the
// wall-sense FSM states. Honours GHOST_GATE_PASS_EN: when defined, gate tiles
// are passable so ghosts can leave the pen.
package maze_pkg;

  localparam int MAP_COLS   = 40;
  localparam int MAP_ROWS   = 30;
  localparam int TILE_SHIFT = 4;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_WALL  = 2'd1,
    TILE_DOT   = 2'd2,
    TILE_GATE  = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    DIR_UP = 2'd0,
    DIR_DN = 2'd1,
    DIR_LT = 2'd2,
    DIR_RT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_UP = 3'd1,
    RD_DN = 3'd2,
    RD_LT = 3'd3,
    RD_RT = 3'd4,
    LAST  = 3'd5
  } ws_state_t;

  // Tile code to blocking decision; the gate is only passable with the macro.
  function automatic logic tile_is_wall(input logic [1:0] code);
`ifdef GHOST_GATE_PASS_EN
    return (code == TILE_WALL);
`else
    return (code == TILE_WALL) || (code == TILE_GATE);
`endif
  endfunction

endpackage

// File: rtl/maze_probe_addr.sv
// Combinational pixel-to-tile-address converter. Takes an 11-bit signed probe
// point and returns row*MAP_COLS+col plus a flag when the point lies outside
// the maze (negative, or column/row beyond the map).
module maze_probe_addr #(
  parameter int MAP_COLS   = maze_pkg::MAP_COLS,
  parameter int MAP_ROWS   = maze_pkg::MAP_ROWS,
  parameter int TILE_SHIFT = maze_pkg::TILE_SHIFT,
  parameter int ADDR_W     = 11
) (
  input  logic signed [10:0]  px,
  input  logic signed [10:0]  py,
  output logic [ADDR_W-1:0]   addr,
  output logic                oor
);

  logic [10:0] col_w;
  logic [10:0] row_w;
  logic [21:0] lin;

  // Tile coordinates, range flag and linear ROM address.
  always_comb begin
    col_w = 11'($unsigned(px) >> TILE_SHIFT);
    row_w = 11'($unsigned(py) >> TILE_SHIFT);
    oor   = px[10] | py[10] |
            (col_w >= 11'(MAP_COLS)) | (row_w >= 11'(MAP_ROWS));
    lin   = 22'(row_w) * 22'(MAP_COLS) + 22'(col_w);
    addr  = ADDR_W'(lin);
  end

endmodule

// File: rtl/ghost_wall_sense.sv
// Ghost wall sensing. Each frame_clk rise triggers four reads of the tile ROM
// one pixel beyond the ghost's box (up, down, left, right) and then loads all
// four wall flags at once with a one-cycle walls_valid pulse.
// Optional feature macro: GHOST_GATE_PASS_EN (gate tiles decode as open).
//
// Interface timing: rom_rd is a single-cycle read request; rom_addr is valid
// whenever rom_rd is high and rom_data answers on the following cycle.
// walls_valid is a one-cycle pulse with no back-pressure; the wall outputs
// hold their value until the next pulse.
module ghost_wall_sense #(
  parameter int MAP_COLS    = maze_pkg::MAP_COLS,
  parameter int MAP_ROWS    = maze_pkg::MAP_ROWS,
  parameter int TILE_SHIFT  = maze_pkg::TILE_SHIFT,
  parameter int ADDR_W      = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [9:0]           GhostX,
  input  logic [9:0]           GhostY,
  input  logic [9:0]           GhostS,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 rom_rd,
  input  logic [1:0]           rom_data,
  output logic                 UpWall,
  output logic                 DownWall,
  output logic                 LeftWall,
  output logic                 RightWall,
  output logic                 walls_valid,
  output maze_pkg::ws_state_t  state
);

  import maze_pkg::*;

  ws_state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   frame_evt;
  logic                   pending_q;
  logic                   start;

  logic [9:0]             gx_q, gy_q, gs_q;
  logic signed [10:0]     sx, sy, ss;
  logic signed [10:0]     probe_x, probe_y;
  logic [ADDR_W-1:0]      probe_addr;
  logic                   probe_oor;
  logic                   rd_slot;
  logic [ADDR_W-1:0]      addr_q;
  logic                   prev_oor_q;
  logic                   slot_wall;
  logic                   up_t, dn_t, lt_t;

  assign frame_evt = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign start     = frame_evt | pending_q;
  assign state     = state_q;

  // Synchronise the asynchronous frame strobe and keep one history bit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], frame_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: fixed walk up, down, left, right, then the final sample slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RD_UP;
      RD_UP:   state_d = RD_DN;
      RD_DN:   state_d = RD_LT;
      RD_LT:   state_d = RD_RT;
      RD_RT:   state_d = LAST;
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame events arriving mid-sequence collapse into one pending request.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)               pending_q <= 1'b0;
    else if (state_q == IDLE) begin
      if (start)              pending_q <= 1'b0;
    end else if (frame_evt)   pending_q <= 1'b1;
  end

  // Snapshot the ghost geometry so all four probes use one coherent position.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gx_q <= '0;
      gy_q <= '0;
      gs_q <= '0;
    end else if (state_q == IDLE && start) begin
      gx_q <= GhostX;
      gy_q <= GhostY;
      gs_q <= GhostS;
    end
  end

  assign sx = signed'({1'b0, gx_q});
  assign sy = signed'({1'b0, gy_q});
  assign ss = signed'({1'b0, gs_q});

  // Probe point for the current read slot.
  always_comb begin
    probe_x = sx;
    probe_y = sy - ss - 11'sd1;
    rd_slot = 1'b0;
    case (state_q)
      RD_UP: begin probe_y = sy - ss - 11'sd1; rd_slot = 1'b1; end
      RD_DN: begin probe_y = sy + ss + 11'sd1; rd_slot = 1'b1; end
      RD_LT: begin probe_x = sx - ss - 11'sd1; probe_y = sy; rd_slot = 1'b1; end
      RD_RT: begin probe_x = sx + ss + 11'sd1; probe_y = sy; rd_slot = 1'b1; end
      default: ;
    endcase
  end

  maze_probe_addr #(
    .MAP_COLS   (MAP_COLS),
    .MAP_ROWS   (MAP_ROWS),
    .TILE_SHIFT (TILE_SHIFT),
    .ADDR_W     (ADDR_W)
  ) u_probe (
    .px   (probe_x),
    .py   (probe_y),
    .addr (probe_addr),
    .oor  (probe_oor)
  );

  // Read request; the address output holds its last issued value otherwise.
  always_comb begin
    rom_rd   = rd_slot & ~probe_oor;
    rom_addr = rom_rd ? probe_addr : addr_q;
  end

  // Remember the last issued address and whether the previous slot was off-map.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q     <= '0;
      prev_oor_q <= 1'b0;
    end else begin
      if (rom_rd) addr_q <= probe_addr;
      prev_oor_q <= probe_oor;
    end
  end

  // Off-map probes count as walls so ghosts never leave the maze.
  assign slot_wall = prev_oor_q | tile_is_wall(rom_data);

  // Collect each direction a cycle after its read; publish all four together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      up_t        <= 1'b0;
      dn_t        <= 1'b0;
      lt_t        <= 1'b0;
      UpWall      <= 1'b0;
      DownWall    <= 1'b0;
      LeftWall    <= 1'b0;
      RightWall   <= 1'b0;
      walls_valid <= 1'b0;
    end else begin
      walls_valid <= 1'b0;
      case (state_q)
        RD_DN: up_t <= slot_wall;
        RD_LT: dn_t <= slot_wall;
        RD_RT: lt_t <= slot_wall;
        LAST: begin
          UpWall      <= up_t;
          DownWall    <= dn_t;
          LeftWall    <= lt_t;
          RightWall   <= slot_wall;
          walls_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_wall_sense.sv
// Bench for ghost_wall_sense: tile ROM model, scoreboard of expected ROM reads
// and wall results, monitor comparing at each read and each walls_valid pulse.
module tb_ghost_wall_sense;
  import maze_pkg::*;

`ifdef GHOST_GATE_PASS_EN
  localparam bit GATE_PASS = 1'b1;
`else
  localparam bit GATE_PASS = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  GhostX = '0, GhostY = '0, GhostS = '0;
  logic [10:0] rom_addr;
  logic        rom_rd;
  logic [1:0]  rom_data = '0;
  logic        UpWall, DownWall, LeftWall, RightWall, walls_valid;
  ws_state_t   state;

  logic [1:0]  rom_mem [0:2047];

  int n_vec   = 0;
  int n_fail  = 0;
  int n_valid = 0;

  logic [10:0] exp_addr_q [$];
  logic [3:0]  exp_q [$];

  ghost_wall_sense dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .GhostX      (GhostX),
    .GhostY      (GhostY),
    .GhostS      (GhostS),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .UpWall      (UpWall),
    .DownWall    (DownWall),
    .LeftWall    (LeftWall),
    .RightWall   (RightWall),
    .walls_valid (walls_valid),
    .state       (state)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  // Synchronous tile ROM, one-cycle read latency.
  always @(posedge Clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  function automatic logic blocks(input logic [1:0] code);
    return (code == 2'd1) || (code == 2'd3 && !GATE_PASS);
  endfunction

  task automatic fill_rom(input int mode);
    for (int i = 0; i < 2048; i++)
      rom_mem[i] = (mode == 0) ? 2'd0 : (mode == 1) ? 2'd1 : 2'($urandom_range(0, 3));
  endtask

  // Reference: probe each side in pixel space, push expected reads and result.
  task automatic expect_frame(input int x, input int y, input int s);
    int px, py;
    logic [3:0] w;
    GhostX = 10'(x);
    GhostY = 10'(y);
    GhostS = 10'(s);
    w = '0;
    for (int d = 0; d < 4; d++) begin
      px = x;
      py = y;
      case (d)
        0:       py = y - s - 1;
        1:       py = y + s + 1;
        2:       px = x - s - 1;
        default: px = x + s + 1;
      endcase
      if (px < 0 || py < 0 || px / 16 >= 40 || py / 16 >= 30) w[3-d] = 1'b1;
      else begin
        exp_addr_q.push_back(11'((py / 16) * 40 + px / 16));
        w[3-d] = blocks(rom_mem[(py / 16) * 40 + px / 16]);
      end
    end
    exp_q.push_back(w);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && k < 60) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 60) fail_now(name, 32'(exp_q.size()));
    repeat (3) @(negedge Clk);
  endtask

  // Monitor: compare every ROM read and every result pulse with the scoreboard.
  always @(negedge Clk) begin
    if (Reset) begin
      if (rom_rd) begin
        if (exp_addr_q.size() == 0) fail_now("rom_rd_extra", 32'(rom_addr));
        else check("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
      end
      if (walls_valid) begin
        n_valid++;
        if (exp_q.size() == 0) fail_now("walls_valid_extra", 32'({UpWall, DownWall, LeftWall, RightWall}));
        else check("walls", 32'({UpWall, DownWall, LeftWall, RightWall}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int lat;
    int v0;
    logic [15:0] rd_mask;

    // Reset state
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_walls", 32'({UpWall, DownWall, LeftWall, RightWall}), 32'h0);
    check("rst_valid", 32'(walls_valid), 32'h0);
    check("rst_rd", 32'(rom_rd), 32'h0);
    check("rst_addr", 32'(rom_addr), 32'h0);
    check("rst_state", 32'(state), 32'(IDLE));
    Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // Empty maze, reference position: latency and read slots
    fill_rom(0);
    expect_frame(231, 240, 9);
    lat = 0;
    rd_mask = '0;
    frame_clk = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      if (k == 3) frame_clk = 1'b0;
      rd_mask[k] = rom_rd;
      if (walls_valid && lat == 0) lat = k;
    end
    check("latency", 32'(lat), 32'd8);
    check("read_slots", 32'(rd_mask), 32'h0078);
    wait_done("timeout_empty");

    // Wall above, gate to the right
    fill_rom(0);
    rom_mem[574] = 2'd1;
    rom_mem[615] = 2'd3;
    expect_frame(231, 240, 9);
    frame_pulse();
    wait_done("timeout_gate");
    check("gate_case", 32'({UpWall, DownWall, LeftWall, RightWall}),
          GATE_PASS ? 32'h8 : 32'h9);

    // Top-right corner: up and right probes off the map
    fill_rom(0);
    expect_frame(635, 5, 9);
    frame_pulse();
    wait_done("timeout_corner");
    check("corner_case", 32'({UpWall, DownWall, LeftWall, RightWall}), 32'h9);

    // Extra rises while busy collapse into one more sequence
    fill_rom(2);
    expect_frame(300, 200, 12);
    expect_frame(300, 200, 12);
    v0 = n_valid;
    for (int i = 0; i < 6; i++) begin
      frame_clk = (i % 2 == 0);
      @(negedge Clk);
    end
    frame_clk = 1'b0;
    wait_done("timeout_busy");
    repeat (5) @(negedge Clk);
    check("busy_pulses", 32'(n_valid - v0), 32'd2);

    // All-wall result, then reset in the middle of the next sequence
    fill_rom(1);
    expect_frame(231, 240, 9);
    frame_pulse();
    wait_done("timeout_allwall");
    check("allwall", 32'({UpWall, DownWall, LeftWall, RightWall}), 32'hF);
    expect_frame(231, 240, 9);
    frame_clk = 1'b1;
    begin
      int k = 0;
      while (state != RD_LT && k < 20) begin
        @(negedge Clk);
        k++;
      end
      if (k >= 20) fail_now("timeout_rd_lt", 32'(state));
    end
    frame_clk = 1'b0;
    Reset = 1'b0;
    #1;
    check("midrst_walls", 32'({UpWall, DownWall, LeftWall, RightWall}), 32'h0);
    check("midrst_valid", 32'(walls_valid), 32'h0);
    check("midrst_state", 32'(state), 32'(IDLE));
    exp_q.delete();
    exp_addr_q.delete();
    v0 = n_valid;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (10) @(negedge Clk);
    check("midrst_no_pulse", 32'(n_valid - v0), 32'd0);
    fill_rom(2);
    expect_frame(231, 240, 9);
    frame_pulse();
    wait_done("timeout_after_rst");

    // Randomised positions over random mazes
    for (int t = 0; t < 25; t++) begin
      int x, y, s;
      fill_rom(2);
      x = $urandom_range(0, 660);
      y = $urandom_range(0, 500);
      s = (t % 5 == 4) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
      expect_frame(x, y, s);
      frame_pulse();
      wait_done("timeout_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
